adder_measure_sequencer: RTL and testbench

- Sequences one delay measurement of the instrumented Brent-Kung adder inside the wrapped project.
- Accepts a measurement request with two operands and a gate length, drives the operands, and clears then enables the adder's ring/chain counter for a fixed window.
- Captures the counter value and presents it with a valid/ack handshake.
- Sits between the LA-register decode and the instrumented adder; runs only while the project's active select is high.

---
 rtl/adder_meas_pkg.sv | 20 ++
 rtl/adder_measure_sequencer_gate.sv | 34 +++
 rtl/adder_measure_sequencer.sv | 155 +++++++++++++++
 tb/tb_adder_measure_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_meas_pkg.sv
// Shared definitions for the adder delay-measurement sequencer.
//   meas_state_t    : sequencer phases (idle, operand settle, counting window,
//                     counter drain, capture, result handshake)
//   DEFAULT_SETTLE  : cycles operands settle before the counter is enabled
//   DEFAULT_DRAIN   : cycles after counter disable before the count is captured
package adder_meas_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } meas_state_t;

    localparam int unsigned DEFAULT_SETTLE = 4;
    localparam int unsigned DEFAULT_DRAIN  = 2;

endpackage

// File: rtl/adder_measure_sequencer_gate.sv
// meas_gate_counter: loadable down-counter timing the settle, gate and drain
// phases of one measurement.
//   wb_clk_i    : system clock
//   wb_rst_i    : synchronous active-high reset
//   load        : load load_value this cycle (takes priority over counting)
//   load_value  : phase length in clocks
//   terminal    : high while the count is 1, i.e. the last cycle of the phase
module meas_gate_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          terminal
);

    logic [CW-1:0] count;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    always_comb begin
        terminal = (count == CW'(1));
    end

endmodule

// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer: runs one delay measurement of the instrumented
// Brent-Kung adder. Operands are driven, the ring/chain counter is cleared,
// enabled for gate_cycles clocks, allowed to drain through its synchroniser,
// and the count is captured and offered with a valid/ack handshake.
//   wb_clk_i, wb_rst_i      : clock, synchronous active-high reset
//   active                  : project select; low aborts a measurement
//   start                   : measurement request (accepted only when idle)
//   a_value, b_value        : operands, sampled on accepted start
//   ext_mode, gate_cycles   : path select and window length, sampled on start
//   cnt_in                  : synchronised count from the adder
//   a_input, b_input, ext_sel : operand / path drive to the adder
//   cnt_clear, cnt_en       : counter control to the adder
//   busy                    : measurement in progress
//   result, overflow        : captured count and its all-ones flag
//   result_valid, result_ack: result handshake
module adder_measure_sequencer
    import adder_meas_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GATE_W = 16,
    parameter int unsigned SETTLE = DEFAULT_SETTLE,
    parameter int unsigned DRAIN  = DEFAULT_DRAIN
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              active,
    input  logic              start,
    input  logic [WIDTH-1:0]  a_value,
    input  logic [WIDTH-1:0]  b_value,
    input  logic              ext_mode,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [WIDTH-1:0]  cnt_in,
    output logic [WIDTH-1:0]  a_input,
    output logic [WIDTH-1:0]  b_input,
    output logic              ext_sel,
    output logic              cnt_clear,
    output logic              cnt_en,
    output logic              busy,
    output logic [WIDTH-1:0]  result,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              overflow
);

    localparam logic [GATE_W-1:0] SETTLE_CNT = GATE_W'(SETTLE);
    localparam logic [GATE_W-1:0] DRAIN_CNT  = GATE_W'(DRAIN);

    meas_state_t       state_q;
    meas_state_t       state_next;
    logic [GATE_W-1:0] gate_q;
    logic              ctr_load;
    logic [GATE_W-1:0] ctr_value;
    logic              ctr_term;

    meas_gate_counter #(.CW(GATE_W)) u_gate (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .load       (ctr_load),
        .load_value (ctr_value),
        .terminal   (ctr_term)
    );

    always_comb begin
        state_next = state_q;
        ctr_load   = 1'b0;
        ctr_value  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start && active) begin
                    state_next = S_LOAD;
                    ctr_load   = 1'b1;
                    ctr_value  = SETTLE_CNT;
                end
            end
            S_LOAD: begin
                if (ctr_term) begin
                    // A zero gate skips counting and draining entirely.
                    if (gate_q == '0) begin
                        state_next = S_CAPTURE;
                    end else begin
                        state_next = S_RUN;
                        ctr_load   = 1'b1;
                        ctr_value  = gate_q;
                    end
                end
            end
            S_RUN: begin
                if (ctr_term) begin
                    state_next = S_DRAIN;
                    ctr_load   = 1'b1;
                    ctr_value  = DRAIN_CNT;
                end
            end
            S_DRAIN: begin
                if (ctr_term) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: state_next = S_DONE;
            S_DONE: begin
                if (result_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Deselect aborts an in-flight measurement; a finished result is kept.
        if (!active && state_q != S_IDLE && state_q != S_DONE) begin
            state_next = S_IDLE;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            gate_q       <= '0;
            a_input      <= '0;
            b_input      <= '0;
            ext_sel      <= 1'b0;
            cnt_clear    <= 1'b0;
            cnt_en       <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state_q   <= state_next;
            cnt_clear <= (state_next == S_LOAD);
            cnt_en    <= (state_next == S_RUN);
            busy      <= (state_next != S_IDLE);
            if (state_q == S_IDLE && state_next == S_LOAD) begin
                a_input <= a_value;
                b_input <= b_value;
                ext_sel <= ext_mode;
                gate_q  <= gate_cycles;
            end
            if (state_q == S_CAPTURE && state_next == S_DONE) begin
                result_valid <= 1'b1;
                if (gate_q == '0) begin
                    result   <= '0;
                    overflow <= 1'b0;
                end else begin
                    result   <= cnt_in;
                    overflow <= &cnt_in;
                end
            end
            if (state_q == S_DONE && state_next == S_IDLE) begin
                result_valid <= 1'b0;
                overflow     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
module tb_adder_measure_sequencer;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned GATE_W = 16;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned DRAIN  = 2;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i = 1'b1;
    logic              active = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  a_value = '0;
    logic [WIDTH-1:0]  b_value = '0;
    logic              ext_mode = 1'b0;
    logic [GATE_W-1:0] gate_cycles = '0;
    logic [WIDTH-1:0]  cnt_in = '0;
    logic              result_ack = 1'b0;
    logic [WIDTH-1:0]  a_input, b_input, result;
    logic              ext_sel, cnt_clear, cnt_en, busy, result_valid, overflow;

    int errors = 0;
    int checks = 0;

    // Observation totals, written only by the monitor below.
    int   en_total = 0;
    int   clr_total = 0;
    int   rv_total = 0;
    logic rv_prev = 1'b0;

    // Adder instrumentation model: counter cleared to cnt_base, +1 per enabled clock,
    // or stuck at all ones in ovf_mode.
    logic             ovf_mode = 1'b0;
    logic [WIDTH-1:0] cnt_base = '0;
    logic [WIDTH-1:0] last_result = '0;

    adder_measure_sequencer #(
        .WIDTH(WIDTH), .GATE_W(GATE_W), .SETTLE(SETTLE), .DRAIN(DRAIN)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .active(active), .start(start),
        .a_value(a_value), .b_value(b_value), .ext_mode(ext_mode),
        .gate_cycles(gate_cycles), .cnt_in(cnt_in), .a_input(a_input),
        .b_input(b_input), .ext_sel(ext_sel), .cnt_clear(cnt_clear),
        .cnt_en(cnt_en), .busy(busy), .result(result),
        .result_valid(result_valid), .result_ack(result_ack), .overflow(overflow)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        if (ovf_mode)       cnt_in <= '1;
        else if (cnt_clear) cnt_in <= cnt_base;
        else if (cnt_en)    cnt_in <= cnt_in + 1;
    end

    always @(negedge wb_clk_i) begin
        if (cnt_en)    en_total++;
        if (cnt_clear) clr_total++;
        if (result_valid && !rv_prev) rv_total++;
        rv_prev = result_valid;
    end

    function automatic int exp_latency(input int g);
        return (g == 0) ? 2 + SETTLE : 2 + SETTLE + g + DRAIN;
    endfunction

    function automatic logic [WIDTH-1:0] exp_result(input int g);
        if (g == 0) return '0;
        if (ovf_mode) return '1;
        return cnt_base + WIDTH'(g);
    endfunction

    // Leaves the caller at the negedge just after the start was sampled.
    task automatic issue_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic ext, input int g);
        @(negedge wb_clk_i);
        a_value = a; b_value = b; ext_mode = ext; gate_cycles = GATE_W'(g);
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        a_value = $urandom; b_value = $urandom; ext_mode = ~ext;
        gate_cycles = GATE_W'($urandom_range(1, 50));
    endtask

    // Clock edges since start was sampled (that edge counts as 1).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!result_valid && lat < 400) begin
            @(negedge wb_clk_i);
            lat++;
        end
    endtask

    task automatic wait_cnt_en(input logic level);
        int n = 0;
        while (cnt_en !== level && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        checks++;
        if (cnt_en !== level) begin
            errors++;
            $display("FAIL wait_cnt_en: cnt_en=%b never reached %b", cnt_en, level);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        checks++;
        if ({a_input, b_input, result} !== '0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h result=%h expected 0", a_input, b_input, result);
        end
        checks++;
        if ({ext_sel, cnt_clear, cnt_en, busy, result_valid, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {ext_sel, cnt_clear, cnt_en, busy, result_valid, overflow});
        end
    endtask

    task automatic test_basic;
        int lat, en0, clr0;
        ovf_mode = 1'b0; cnt_base = '0;
        en0 = en_total; clr0 = clr_total;
        issue_start(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 10);
        checks++;
        if (busy !== 1'b1 || cnt_clear !== 1'b1) begin
            errors++;
            $display("FAIL basic_load: busy=%b cnt_clear=%b expected 1 1", busy, cnt_clear);
        end
        wait_valid(lat);
        checks++;
        if (lat != 18) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 18", lat);
        end
        checks++;
        if (clr_total - clr0 != 4) begin
            errors++;
            $display("FAIL basic_clear_cycles: got %0d expected 4", clr_total - clr0);
        end
        checks++;
        if (en_total - en0 != 10) begin
            errors++;
            $display("FAIL basic_en_cycles: got %0d expected 10", en_total - en0);
        end
        checks++;
        if (result !== 32'd10 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %h ovf=%b expected 0000000a ovf=0", result, overflow);
        end
        checks++;
        if (a_input !== 32'h1 || b_input !== 32'hFFFF_FFFF || ext_sel !== 1'b1) begin
            errors++;
            $display("FAIL basic_operands: a=%h b=%h ext=%b expected 00000001 ffffffff 1",
                     a_input, b_input, ext_sel);
        end
        result_ack = 1'b1;
        @(negedge wb_clk_i);
        result_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || a_input !== 32'h1) begin
            errors++;
            $display("FAIL basic_ack: valid=%b busy=%b a=%h expected 0 0 00000001",
                     result_valid, busy, a_input);
        end
        last_result = 32'd10;
    endtask

    task automatic test_zero_gate;
        int lat, en0;
        ovf_mode = 1'b1;
        en0 = en_total;
        issue_start($urandom, $urandom, 1'b0, 0);
        wait_valid(lat);
        checks++;
        if (lat != exp_latency(0) || en_total != en0) begin
            errors++;
            $display("FAIL zero_gate_timing: lat=%0d en=%0d expected %0d 0",
                     lat, en_total - en0, exp_latency(0));
        end
        checks++;
        if (result !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL zero_gate_result: got %h ovf=%b expected 0 ovf=0", result, overflow);
        end
        result_ack = 1'b1;
        @(negedge wb_clk_i);
        result_ack = 1'b0;
        ovf_mode = 1'b0;
        last_result = '0;
    endtask

    task automatic test_overflow;
        int lat;
        ovf_mode = 1'b1;
        issue_start($urandom, $urandom, 1'b1, 3);
        wait_valid(lat);
        checks++;
        if (lat != exp_latency(3) || result !== '1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: lat=%0d result=%h ovf=%b expected %0d ffffffff 1",
                     lat, result, overflow, exp_latency(3));
        end
        result_ack = 1'b1;
        @(negedge wb_clk_i);
        result_ack = 1'b0;
        checks++;
        if (overflow !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b valid=%b expected 0 0", overflow, result_valid);
        end
        ovf_mode = 1'b0;
        last_result = '1;
    endtask

    task automatic test_busy_reject;
        int lat, rv0;
        logic [WIDTH-1:0] a1;
        a1 = $urandom | 32'h1_0000;
        cnt_base = '0;
        rv0 = rv_total;
        issue_start(a1, $urandom, 1'b0, 12);
        wait_cnt_en(1'b1);
        a_value = 32'h1234; start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        wait_valid(lat);
        checks++;
        if (a_input !== a1 || result !== exp_result(12)) begin
            errors++;
            $display("FAIL busy_reject_data: a=%h result=%h expected %h %h",
                     a_input, result, a1, exp_result(12));
        end
        result_ack = 1'b1;
        @(negedge wb_clk_i);
        result_ack = 1'b0;
        repeat (6) @(negedge wb_clk_i);
        checks++;
        if (rv_total - rv0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_reject_count: valids=%0d busy=%b expected 1 0", rv_total - rv0, busy);
        end
        last_result = exp_result(12);
    endtask

    task automatic test_abort;
        int rv0;
        rv0 = rv_total;
        issue_start($urandom, $urandom, 1'b1, 20);
        wait_cnt_en(1'b1);
        repeat (3) @(negedge wb_clk_i);
        active = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if ({busy, cnt_en, cnt_clear, result_valid} !== 4'b0 || result !== last_result) begin
            errors++;
            $display("FAIL abort_state: busy/en/clr/valid=%b result=%h expected 0000 %h",
                     {busy, cnt_en, cnt_clear, result_valid}, result, last_result);
        end
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_inactive_start: busy=%b expected 0", busy);
        end
        active = 1'b1;
        repeat (40) @(negedge wb_clk_i);
        checks++;
        if (rv_total != rv0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result: valids=%0d busy=%b expected 0 0", rv_total - rv0, busy);
        end
    endtask

    task automatic test_reset_drain;
        issue_start($urandom | 32'h1, $urandom | 32'h1, 1'b1, 5);
        wait_cnt_en(1'b1);
        wait_cnt_en(1'b0);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        checks++;
        if ({a_input, b_input, result} !== '0) begin
            errors++;
            $display("FAIL reset_drain_data: a=%h b=%h result=%h expected 0", a_input, b_input, result);
        end
        checks++;
        if ({ext_sel, cnt_clear, cnt_en, busy, result_valid, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_drain_flags: got %b expected 000000",
                     {ext_sel, cnt_clear, cnt_en, busy, result_valid, overflow});
        end
        last_result = '0;
    endtask

    task automatic test_handshake;
        int lat;
        logic [WIDTH-1:0] exp;
        cnt_base = $urandom;
        exp = exp_result(7);
        issue_start($urandom, $urandom, 1'b0, 7);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            checks++;
            if (result_valid !== 1'b1 || busy !== 1'b1 || result !== exp) begin
                errors++;
                $display("FAIL handshake_hold: cycle %0d valid=%b busy=%b result=%h expected 1 1 %h",
                         i, result_valid, busy, result, exp);
            end
        end
        // Ack and start together in DONE: ack wins, start is dropped.
        result_ack = 1'b1; start = 1'b1; gate_cycles = GATE_W'(3);
        @(negedge wb_clk_i);
        result_ack = 1'b0; start = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake_release: valid=%b busy=%b expected 0 0", result_valid, busy);
        end
        issue_start(32'hA5A5_0001, 32'h5A5A_0002, 1'b1, 2);
        checks++;
        if (busy !== 1'b1 || cnt_clear !== 1'b1) begin
            errors++;
            $display("FAIL handshake_restart: busy=%b clr=%b expected 1 1", busy, cnt_clear);
        end
        wait_valid(lat);
        checks++;
        if (lat != exp_latency(2) || result !== exp_result(2)) begin
            errors++;
            $display("FAIL handshake_second: lat=%0d result=%h expected %0d %h",
                     lat, result, exp_latency(2), exp_result(2));
        end
        result_ack = 1'b1;
        @(negedge wb_clk_i);
        result_ack = 1'b0;
        last_result = exp_result(2);
    endtask

    task automatic test_random;
        int lat, en0, g, d;
        logic [WIDTH-1:0] a, b, exp;
        logic ext;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; ext = 1'($urandom_range(0, 1));
            g = (i == 0) ? 1 : int'($urandom_range(0, 25));
            cnt_base = (i == 5) ? 32'hFFFF_FFF0 : $urandom;
            ovf_mode = (i == 3);
            exp = exp_result(g);
            en0 = en_total;
            issue_start(a, b, ext, g);
            wait_valid(lat);
            checks++;
            if (lat != exp_latency(g) || en_total - en0 != g) begin
                errors++;
                $display("FAIL rand_timing[%0d]: gate=%0d lat=%0d en=%0d expected %0d %0d",
                         i, g, lat, en_total - en0, exp_latency(g), g);
            end
            checks++;
            if (result !== exp || overflow !== (&exp)) begin
                errors++;
                $display("FAIL rand_result[%0d]: got %h ovf=%b expected %h ovf=%b",
                         i, result, overflow, exp, &exp);
            end
            checks++;
            if (a_input !== a || b_input !== b || ext_sel !== ext) begin
                errors++;
                $display("FAIL rand_operands[%0d]: a=%h b=%h ext=%b expected %h %h %b",
                         i, a_input, b_input, ext_sel, a, b, ext);
            end
            d = int'($urandom_range(0, 3));
            repeat (d) @(negedge wb_clk_i);
            result_ack = 1'b1;
            @(negedge wb_clk_i);
            result_ack = 1'b0;
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL rand_ack[%0d]: valid=%b busy=%b ovf=%b expected 0 0 0",
                         i, result_valid, busy, overflow);
            end
        end
        ovf_mode = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_gate;
        test_overflow;
        test_busy_reject;
        test_abort;
        test_reset_drain;
        test_handshake;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
